// File: rtl/blake2s_feed_pkg.sv
// Shared definitions for the BLAKE2s message feeder: FSM states, default
// block/counter sizes and the byte used to pad a short final block.
package blake2s_feed_pkg;

  localparam int unsigned BB_DEFAULT  = 64;
  localparam int unsigned LLW_DEFAULT = 64;
  localparam logic [7:0]  PAD_BYTE    = 8'h00;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } feed_state_t;

endpackage

// File: rtl/blake2s_feed_buf.sv
// Block buffer: BB x 8-bit register file, one write port, one async read port.
// Ports: clk; wr_en/wr_idx/wr_data write side; rd_idx/rd_data_c read side.
module blake2s_feed_buf #(
  parameter int unsigned BB = 64
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [$clog2(BB)-1:0] wr_idx,
  input  logic [7:0]            wr_data,
  input  logic [$clog2(BB)-1:0] rd_idx,
  output logic [7:0]            rd_data_c
);

  logic [7:0] mem [BB];

  // Contents are not reset; stale bytes are masked by the fill count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/blake2s_feed.sv
// BLAKE2s message feeder: collects a byte stream into BB-byte blocks and
// replays each block to the hash core one byte per cycle, zero padded, with
// first/last block flags and the running message byte count.
// Ports: clk, nreset (async active-low); s_valid_i/s_ready_o/s_data_i/
// s_last_i/s_empty_i/nn_i upstream; kk_o/nn_o/ll_o/block_first_o/
// block_last_o/data_v_o/data_idx_o/data_o/ready_v_i towards the core.
// Option: BLAKE2_FEED_ERR_EN adds sticky err_o for misuse of s_empty_i.
module blake2s_feed
  import blake2s_feed_pkg::*;
#(
  parameter int unsigned BB  = BB_DEFAULT,
  parameter int unsigned LLW = LLW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [7:0]            s_data_i,
  input  logic                  s_last_i,
  input  logic                  s_empty_i,
  input  logic [5:0]            nn_i,
  output logic [5:0]            kk_o,
  output logic [5:0]            nn_o,
  output logic [LLW-1:0]        ll_o,
  output logic                  block_first_o,
  output logic                  block_last_o,
  output logic                  data_v_o,
  output logic [$clog2(BB)-1:0] data_idx_o,
  output logic [7:0]            data_o,
`ifdef BLAKE2_FEED_ERR_EN
  output logic                  err_o,
`endif
  input  logic                  ready_v_i
);

  localparam int unsigned IW = $clog2(BB);
  localparam int unsigned CW = IW + 1;

  feed_state_t    state, state_nxt;
  logic [CW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic [LLW-1:0] ll_cnt;
  logic           first_blk, last_blk, msg_active;
  logic [7:0]     rd_data;

  logic           accept_c, empty_end_c, wr_en_c, fill_done_c, send_done_c;
  logic           s_ready_nxt, data_v_nxt, first_nxt, last_nxt;
  logic [IW-1:0]  data_idx_nxt;
  logic [7:0]     data_nxt;

  assign kk_o = 6'd0;

  blake2s_feed_buf #(.BB(BB)) u_buf (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_idx    (wr_idx[IW-1:0]),
    .wr_data   (s_data_i),
    .rd_idx    (rd_idx),
    .rd_data_c (rd_data)
  );

  // Beat qualification; an empty+last beat terminates without storing a byte.
  always_comb begin
    accept_c    = (state == FILL) & s_valid_i & s_ready_o;
    empty_end_c = s_empty_i & s_last_i;
    wr_en_c     = accept_c & ~empty_end_c;
    fill_done_c = accept_c & (s_last_i | (wr_idx == CW'(BB - 1)));
    send_done_c = (state == SEND) & (rd_idx == IW'(BB - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= FILL;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_done_c) state_nxt = WAIT;
      WAIT:    if (ready_v_i)   state_nxt = SEND;
      SEND:    if (send_done_c) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Output decode, registered below; core outputs trail the SEND state by one cycle.
  always_comb begin
    s_ready_nxt  = (state_nxt == FILL);
    data_v_nxt   = 1'b0;
    data_idx_nxt = '0;
    data_nxt     = PAD_BYTE;
    first_nxt    = 1'b0;
    last_nxt     = 1'b0;
    if (state == SEND) begin
      data_v_nxt   = 1'b1;
      data_idx_nxt = rd_idx;
      data_nxt     = (CW'(rd_idx) < wr_idx) ? rd_data : PAD_BYTE;
      first_nxt    = first_blk;
      last_nxt     = last_blk;
    end
  end

  // Fill/send counters, message flags and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_idx        <= '0;
      rd_idx        <= '0;
      ll_cnt        <= '0;
      first_blk     <= 1'b1;
      last_blk      <= 1'b0;
      msg_active    <= 1'b0;
      nn_o          <= '0;
      ll_o          <= '0;
      s_ready_o     <= 1'b0;
      data_v_o      <= 1'b0;
      data_idx_o    <= '0;
      data_o        <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_idx <= wr_idx + CW'(1);
        ll_cnt <= ll_cnt + LLW'(1);
      end
      if (accept_c && !msg_active) begin
        msg_active <= 1'b1;
        nn_o       <= nn_i;
      end
      if (fill_done_c) last_blk <= s_last_i;
      if (state == SEND) rd_idx <= send_done_c ? '0 : rd_idx + IW'(1);
      // End of block: recycle the buffer; after the last block start a fresh message.
      if (send_done_c) begin
        wr_idx <= '0;
        if (last_blk) begin
          ll_cnt     <= '0;
          first_blk  <= 1'b1;
          last_blk   <= 1'b0;
          msg_active <= 1'b0;
        end else begin
          first_blk  <= 1'b0;
        end
      end
      ll_o          <= ll_cnt;
      s_ready_o     <= s_ready_nxt;
      data_v_o      <= data_v_nxt;
      data_idx_o    <= data_idx_nxt;
      data_o        <= data_nxt;
      block_first_o <= first_nxt;
      block_last_o  <= last_nxt;
    end
  end

`ifdef BLAKE2_FEED_ERR_EN
  // Sticky misuse flag: empty without last, or empty after bytes of the message.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) err_o <= 1'b0;
    else if (accept_c && s_empty_i && (!s_last_i || msg_active)) err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_blake2s_feed.sv
// Directed self-checking bench for blake2s_feed (BB=64, LLW=64).
module tb_blake2s_feed;

  logic        clk = 1'b0;
  logic        nreset;
  logic        s_valid_i, s_ready_o, s_last_i, s_empty_i, ready_v_i;
  logic [7:0]  s_data_i;
  logic [5:0]  nn_i, kk_o, nn_o;
  logic [63:0] ll_o;
  logic        block_first_o, block_last_o, data_v_o;
  logic [5:0]  data_idx_o;
  logic [7:0]  data_o;
`ifdef BLAKE2_FEED_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  blake2s_feed #(.BB(64), .LLW(64)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .s_data_i      (s_data_i),
    .s_last_i      (s_last_i),
    .s_empty_i     (s_empty_i),
    .nn_i          (nn_i),
    .kk_o          (kk_o),
    .nn_o          (nn_o),
    .ll_o          (ll_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o),
    .data_v_o      (data_v_o),
    .data_idx_o    (data_idx_o),
    .data_o        (data_o),
`ifdef BLAKE2_FEED_ERR_EN
    .err_o         (err),
`endif
    .ready_v_i     (ready_v_i)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Block capture: records bytes and flags of each SEND burst, flags protocol slips.
  logic [7:0]  cap [4][64];
  logic        bf [4];
  logic        bl [4];
  logic [63:0] bll [4];
  int nblk = 0, exp_idx = 0, seq_err = 0, clr_req = 0, clr_seen = 0;

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen <= clr_req;
      nblk     <= 0;
      exp_idx  <= 0;
      seq_err  <= 0;
    end else if (!nreset) begin
      exp_idx <= 0;
    end else if (data_v_o) begin
      if (int'(data_idx_o) != exp_idx) seq_err <= seq_err + 1;
      if (nblk < 4) begin
        if (exp_idx == 0) begin
          bf[nblk]  <= block_first_o;
          bl[nblk]  <= block_last_o;
          bll[nblk] <= ll_o;
        end else if (bf[nblk] != block_first_o || bl[nblk] != block_last_o || bll[nblk] != ll_o) begin
          seq_err <= seq_err + 1;
        end
        cap[nblk][data_idx_o] <= data_o;
      end
      if (exp_idx == 63) begin
        exp_idx <= 0;
        nblk    <= nblk + 1;
      end else begin
        exp_idx <= exp_idx + 1;
      end
    end else if (exp_idx != 0) begin
      seq_err <= seq_err + 1;
    end
  end

  logic [7:0] exp_bytes [64];

  function automatic logic [7:0] pat(input int i, input int seed);
    return 8'(i * 7 + seed);
  endfunction

  task automatic clear_mon();
    clr_req++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int t = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    s_empty_i = empty;
    while (!s_ready_o && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready_o) chk("beat_timeout", 64'(s_ready_o), 64'd1);
    @(posedge clk); #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_empty_i = 1'b0;
  endtask

  task automatic send_msg(input int len, input int seed);
    for (int i = 0; i < len; i++) send_beat(pat(i, seed), 1'(i == len - 1), 1'b0);
  endtask

  task automatic send_abc();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
  endtask

  task automatic set_exp_pat(input int len, input int seed, input int off);
    for (int i = 0; i < 64; i++) exp_bytes[i] = (i < len) ? pat(i + off, seed) : 8'h00;
  endtask

  task automatic set_exp_str(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int len);
    for (int i = 0; i < 64; i++) exp_bytes[i] = 8'h00;
    if (len > 0) exp_bytes[0] = a;
    if (len > 1) exp_bytes[1] = b;
    if (len > 2) exp_bytes[2] = c;
  endtask

  task automatic wait_blocks(input string tag, input int n);
    int t = 0;
    while (nblk < n && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (80) @(posedge clk);
    #1;
    chk({tag, "_nblk"}, 64'(nblk), 64'(n));
    chk({tag, "_seq"}, 64'(seq_err), 64'd0);
  endtask

  task automatic check_bytes(input string tag, input int b);
    for (int i = 0; i < 64; i++) chk($sformatf("%s_b%0d_idx%0d", tag, b, i), 64'(cap[b][i]), 64'(exp_bytes[i]));
  endtask

  task automatic check_flags(input string tag, input int b, input logic f, input logic l);
    chk($sformatf("%s_b%0d_first", tag, b), 64'(bf[b]), 64'(f));
    chk($sformatf("%s_b%0d_last", tag, b), 64'(bl[b]), 64'(l));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int viol;
    int t;
    nreset    = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_last_i  = 1'b0;
    s_empty_i = 1'b0;
    nn_i      = 6'd32;
    ready_v_i = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready_o), 64'd0);
    chk("rst_data_v", 64'(data_v_o), 64'd0);
    chk("rst_data_idx", 64'(data_idx_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_first", 64'(block_first_o), 64'd0);
    chk("rst_last", 64'(block_last_o), 64'd0);
    chk("rst_ll", ll_o, 64'd0);
    chk("rst_nn", 64'(nn_o), 64'd0);
    chk("rst_kk", 64'(kk_o), 64'd0);
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_s_ready", 64'(s_ready_o), 64'd1);

    // "abc"
    clear_mon();
    send_abc();
    wait_blocks("abc", 1);
    set_exp_str(8'h61, 8'h62, 8'h63, 3);
    check_flags("abc", 0, 1'b1, 1'b1);
    chk("abc_ll", bll[0], 64'd3);
    check_bytes("abc", 0);
    chk("abc_nn", 64'(nn_o), 64'd32);
    chk("abc_kk", 64'(kk_o), 64'd0);

    // Empty message
    clear_mon();
    send_beat(8'hAA, 1'b1, 1'b1);
    wait_blocks("empty", 1);
    set_exp_pat(0, 0, 0);
    check_flags("empty", 0, 1'b1, 1'b1);
    chk("empty_ll", bll[0], 64'd0);
    check_bytes("empty", 0);

    // Exactly one full block, last on byte 64
    clear_mon();
    send_msg(64, 3);
    wait_blocks("m64", 1);
    set_exp_pat(64, 3, 0);
    check_flags("m64", 0, 1'b1, 1'b1);
    chk("m64_ll", bll[0], 64'd64);
    check_bytes("m64", 0);

    // 65 bytes: full block then one-byte last block
    clear_mon();
    send_msg(65, 5);
    wait_blocks("m65", 2);
    set_exp_pat(64, 5, 0);
    check_flags("m65", 0, 1'b1, 1'b0);
    check_bytes("m65", 0);
    set_exp_pat(1, 5, 64);
    check_flags("m65", 1, 1'b0, 1'b1);
    chk("m65_ll", bll[1], 64'd65);
    check_bytes("m65", 1);

    // Core not ready: hold in WAIT for 10 cycles, then release
    clear_mon();
    ready_v_i = 1'b0;
    send_beat(8'h78, 1'b0, 1'b0);
    send_beat(8'h79, 1'b1, 1'b0);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (s_ready_o || data_v_o) viol++;
      @(posedge clk); #1;
    end
    chk("wait_hold_viol", 64'(viol), 64'd0);
    chk("wait_s_ready", 64'(s_ready_o), 64'd0);
    chk("wait_data_v", 64'(data_v_o), 64'd0);
    chk("wait_nblk", 64'(nblk), 64'd0);
    ready_v_i = 1'b1;
    send_beat(8'h64, 1'b0, 1'b0);
    send_beat(8'h65, 1'b1, 1'b0);
    wait_blocks("wait", 2);
    set_exp_str(8'h78, 8'h79, 8'h00, 2);
    check_flags("wait", 0, 1'b1, 1'b1);
    chk("wait_b0_ll", bll[0], 64'd2);
    check_bytes("wait", 0);
    set_exp_str(8'h64, 8'h65, 8'h00, 2);
    check_flags("wait", 1, 1'b1, 1'b1);
    chk("wait_b1_ll", bll[1], 64'd2);
    check_bytes("wait", 1);

    // Reset during SEND at index 20, then a fresh "abc"
    clear_mon();
    send_msg(10, 9);
    t = 0;
    while (!(data_v_o && data_idx_o == 6'd20) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_send_reached", 64'(data_v_o && data_idx_o == 6'd20), 64'd1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_data_v", 64'(data_v_o), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready_o), 64'd0);
    chk("mid_rst_ll", ll_o, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    nn_i   = 6'd16;
    clear_mon();
    send_abc();
    wait_blocks("rabc", 1);
    set_exp_str(8'h61, 8'h62, 8'h63, 3);
    check_flags("rabc", 0, 1'b1, 1'b1);
    chk("rabc_ll", bll[0], 64'd3);
    check_bytes("rabc", 0);
    chk("rabc_nn", 64'(nn_o), 64'd16);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
